instr_exec_sched: RTL and testbench
===================================

INSTR_EXEC_SCHED -- requirements
Module: instr_exec_sched

Interface
REQ-001 SHALL have parameter DEPTH, default 32, meaning number of instruction register entries (power of two, at most 32).
REQ-002 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-003 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have port start, input, 1, request to execute a batch, sampled only in IDLE.
REQ-005 SHALL have port base_addr, input, address_t (5), address of the first instruction.
REQ-006 SHALL have port count, input, 6, number of instructions, 0..32.
REQ-007 SHALL have port rd_en, output, 1, instruction read strobe.
REQ-008 SHALL have port rd_addr, output, address_t, instruction read address.
REQ-009 SHALL have port rd_instr, input, instruction_t, read data, valid exactly 1 cycle after rd_en.
REQ-010 SHALL have port wr_en, output, 1, result write strobe.
REQ-011 SHALL have port wr_addr, output, address_t, result write address.
REQ-012 SHALL have port wr_res, output, result_t (64, signed), result to store in the res field.
REQ-013 SHALL have port busy, output, 1, high in every state except IDLE.
REQ-014 SHALL have port done, output, 1, one-cycle pulse at batch completion.
REQ-015 SHALL have port exec_cnt, output, 6, number of instructions written back in the current or last batch.
REQ-016 SHALL have port err, output, 1, sticky flag for an unsupported opcode, cleared by the next accepted start.

Function
REQ-017 SHALL implement the states IDLE, READ, EXEC, WRITE and DONE.
REQ-018 IDLE with start=1 SHALL capture base_addr and count, clear exec_cnt and err, and go to READ; if count=0 it SHALL go to DONE instead.
REQ-019 READ SHALL assert rd_en with rd_addr equal to the current address for one cycle, then go to EXEC.
REQ-020 EXEC SHALL capture rd_instr and register the ALU result into wr_res, then go to WRITE.
REQ-021 WRITE SHALL assert wr_en with wr_addr equal to rd_addr of the same instruction and increment exec_cnt.
REQ-022 After WRITE, the FSM SHALL go to READ at address+1 mod DEPTH if instructions remain, otherwise to DONE; 31 wraps to 0.
REQ-023 DONE SHALL assert done for exactly one cycle and return to IDLE.
REQ-024 Latency SHALL be fixed: done is high 3*count+1 cycles after the start cycle (count=0: 1 cycle).
REQ-025 start while busy SHALL be ignored, with no effect on state, counters or err.
REQ-026 Arithmetic SHALL be signed 64-bit with operands sign-extended: ZERO=0, PASSA=op_a, PASSB=op_b, ADD=a+b, SUB=a-b, MULT=full a*b.
REQ-027 DIV SHALL truncate toward zero and MOD SHALL take the sign of op_a; a zero divisor SHALL give 0 with err unchanged.
REQ-028 Opcode values 8..15 SHALL write res=0 and set err.
REQ-029 rd_en, wr_en and done SHALL never be high in the same cycle.

Reset
REQ-030 reset SHALL take priority over all inputs and force IDLE within one clock.
REQ-031 During reset, busy, done, rd_en and wr_en SHALL be 0; rd_addr, wr_addr, wr_res and exec_cnt SHALL be 0; err SHALL be 0.
REQ-032 reset asserted mid-batch SHALL abort the batch with no further writes and no done pulse.

Configuration
REQ-033 Macro INSTR_EXEC_DIV_EN defined SHALL enable DIV and MOD as defined in REQ-027.
REQ-034 Without INSTR_EXEC_DIV_EN, DIV and MOD SHALL be treated as unsupported: res=0 and err set, with no divider logic synthesized.

Verification
REQ-035 start, base=2, count=1, entry 2 holds {ADD, 7, -3}: wr_en at cycle 3 with wr_addr=2, wr_res=4; done at cycle 4.
REQ-036 start, base=30, count=3, all MULT {-65536, 65536}: writes go to 30, 31, 0, each with res=-4294967296; exec_cnt=3; done at cycle 10.
REQ-037 DIV {-7, 2} then MOD {-7, 2}: res=-3 and res=-1; DIV {5, 0}: res=0, err=0 (with INSTR_EXEC_DIV_EN); without the macro, res=0 and err=1.
REQ-038 opcode 4'hF at base=0, count=1: wr_res=0 and err=1 held after done; the next start clears err.
REQ-039 count=0: done at cycle 1, no rd_en or wr_en; start pulsed during busy is ignored.
REQ-040 reset asserted in EXEC of the 2nd of 4 instructions: next cycle IDLE, all outputs 0, no wr_en, no done.

Source files
------------

// File: rtl/instr_exec_sched.sv
// -----------------------------------------------------------------------------
// instr_exec_sched
//
// Sequential instruction executor. On an accepted start it walks `count`
// instruction-register entries beginning at `base_addr`. For each entry it
// reads the instruction, runs it through a signed 64-bit ALU and writes the
// result back to the same address. The address wraps modulo DEPTH.
//
// Per-instruction sequence: READ -> EXEC -> WRITE (3 cycles). A batch
// therefore raises done exactly 3*count+1 cycles after the start cycle.
//
// Instruction word layout (rd_instr, 68 bits):
//   [67:64] opcode
//   [63:32] op_a (signed, 32 bit)
//   [31:0]  op_b (signed, 32 bit)
// Both operands are sign-extended to 64 bits before use.
//
// Opcodes:
//   0 ZERO, 1 PASSA, 2 PASSB, 3 ADD, 4 SUB, 5 MULT, 6 DIV, 7 MOD.
//   8..15 are unsupported: they write 0 and set the sticky err flag.
//
// Optional feature: macro INSTR_EXEC_DIV_EN.
//   Defined     : DIV truncates toward zero and MOD takes the sign of op_a.
//                 A zero divisor yields 0 and leaves err unchanged.
//   Not defined : DIV and MOD behave like unsupported opcodes, and no divider
//                 is built.
//
// Handshake: there is no back-pressure. rd_en is a one-cycle strobe, and
// rd_instr must be valid in the cycle that follows it. wr_en is a one-cycle
// strobe qualifying wr_addr and wr_res. rd_en, wr_en and done are mutually
// exclusive because each one decodes a different FSM state.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous active-high reset
//   start      batch request, sampled only in IDLE
//   base_addr  first instruction address
//   count      number of instructions (0..32)
//   rd_en      instruction read strobe
//   rd_addr    instruction read address
//   rd_instr   instruction read data (one cycle after rd_en)
//   wr_en      result write strobe
//   wr_addr    result write address
//   wr_res     signed 64-bit result
//   busy       high in every state except IDLE
//   done       one-cycle completion pulse
//   exec_cnt   instructions written back in the current/last batch
//   err        sticky unsupported-opcode flag, cleared by an accepted start
//   dbg_state  current FSM state encoding (observation only)
// -----------------------------------------------------------------------------
module instr_exec_sched #(
  parameter int DEPTH = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [4:0]         base_addr,
  input  logic [5:0]         count,
  output logic               rd_en,
  output logic [4:0]         rd_addr,
  input  logic [67:0]        rd_instr,
  output logic               wr_en,
  output logic [4:0]         wr_addr,
  output logic signed [63:0] wr_res,
  output logic               busy,
  output logic               done,
  output logic [5:0]         exec_cnt,
  output logic               err,
  output logic [2:0]         dbg_state
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_EXEC  = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam logic [3:0] OP_ZERO  = 4'd0;
  localparam logic [3:0] OP_PASSA = 4'd1;
  localparam logic [3:0] OP_PASSB = 4'd2;
  localparam logic [3:0] OP_ADD   = 4'd3;
  localparam logic [3:0] OP_SUB   = 4'd4;
  localparam logic [3:0] OP_MULT  = 4'd5;
  localparam logic [3:0] OP_DIV   = 4'd6;
  localparam logic [3:0] OP_MOD   = 4'd7;

  // DEPTH is a power of two no larger than 32, so wrapping is a mask.
  localparam logic [4:0] ADDR_MASK = 5'(DEPTH - 1);

  state_t             state_q, state_d;
  logic [4:0]         addr_q, addr_d;
  logic [5:0]         remain_q, remain_d;
  logic [5:0]         exec_cnt_q, exec_cnt_d;
  logic               err_q, err_d;
  logic signed [63:0] wr_res_q, wr_res_d;

  // ---------------------------------------------------------------------------
  // ALU (combinational, evaluated on rd_instr during EXEC)
  // ---------------------------------------------------------------------------
  logic [3:0]         opcode;
  logic signed [63:0] op_a_ext;
  logic signed [63:0] op_b_ext;
  logic signed [63:0] alu_res;
  logic               alu_bad;

  assign opcode   = rd_instr[67:64];
  assign op_a_ext = {{32{rd_instr[63]}}, rd_instr[63:32]};
  assign op_b_ext = {{32{rd_instr[31]}}, rd_instr[31:0]};

  always_comb begin
    alu_res = '0;
    alu_bad = 1'b0;
    case (opcode)
      OP_ZERO:  alu_res = '0;
      OP_PASSA: alu_res = op_a_ext;
      OP_PASSB: alu_res = op_b_ext;
      OP_ADD:   alu_res = op_a_ext + op_b_ext;
      OP_SUB:   alu_res = op_a_ext - op_b_ext;
      // The product of two sign-extended 32-bit values fits in 64 bits,
      // so the low half of the multiply is the exact result.
      OP_MULT:  alu_res = op_a_ext * op_b_ext;
`ifdef INSTR_EXEC_DIV_EN
      // Signed / and % truncate toward zero, and the remainder takes the
      // dividend's sign. A zero divisor is defined to give 0 and is not
      // treated as an error.
      OP_DIV: begin
        if (op_b_ext != 64'sd0) alu_res = op_a_ext / op_b_ext;
      end
      OP_MOD: begin
        if (op_b_ext != 64'sd0) alu_res = op_a_ext % op_b_ext;
      end
`else
      OP_DIV, OP_MOD: alu_bad = 1'b1;
`endif
      default:  alu_bad = 1'b1;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM next-state and datapath
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    remain_d   = remain_q;
    exec_cnt_d = exec_cnt_q;
    err_d      = err_q;
    wr_res_d   = wr_res_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          addr_d     = base_addr & ADDR_MASK;
          remain_d   = count;
          exec_cnt_d = '0;
          err_d      = 1'b0;
          state_d    = (count == 6'd0) ? ST_DONE : ST_READ;
        end
      end
      ST_READ: begin
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        wr_res_d = alu_res;
        if (alu_bad) err_d = 1'b1;
        state_d = ST_WRITE;
      end
      ST_WRITE: begin
        exec_cnt_d = exec_cnt_q + 6'd1;
        remain_d   = remain_q - 6'd1;
        if (remain_q == 6'd1) begin
          state_d = ST_DONE;
        end else begin
          addr_d  = (addr_q + 5'd1) & ADDR_MASK;
          state_d = ST_READ;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      remain_q   <= '0;
      exec_cnt_q <= '0;
      err_q      <= 1'b0;
      wr_res_q   <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      remain_q   <= remain_d;
      exec_cnt_q <= exec_cnt_d;
      err_q      <= err_d;
      wr_res_q   <= wr_res_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: pure state decodes. Read and write share one address register
  // because the write-back always targets the instruction just read.
  // ---------------------------------------------------------------------------
  assign rd_en     = (state_q == ST_READ);
  assign wr_en     = (state_q == ST_WRITE);
  assign done      = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);
  assign rd_addr   = addr_q;
  assign wr_addr   = addr_q;
  assign wr_res    = wr_res_q;
  assign exec_cnt  = exec_cnt_q;
  assign err       = err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_instr_exec_sched.sv
module tb_instr_exec_sched;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic               start = 1'b0;
  logic [4:0]         base_addr = '0;
  logic [5:0]         count = '0;
  logic               rd_en;
  logic [4:0]         rd_addr;
  logic [67:0]        rd_instr = '0;
  logic               wr_en;
  logic [4:0]         wr_addr;
  logic signed [63:0] wr_res;
  logic               busy;
  logic               done;
  logic [5:0]         exec_cnt;
  logic               err;
  logic [2:0]         dbg_state;

  instr_exec_sched #(.DEPTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .count(count), .rd_en(rd_en), .rd_addr(rd_addr), .rd_instr(rd_instr),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_res(wr_res), .busy(busy),
    .done(done), .exec_cnt(exec_cnt), .err(err), .dbg_state(dbg_state)
  );

  // ---------------------------------------------------------------------------
  // Instruction memory model: data returned one cycle after rd_en
  // ---------------------------------------------------------------------------
  logic [67:0] mem [32];

  always @(posedge clk) begin
    if (rd_en) rd_instr <= mem[rd_addr];
  end

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Scoreboard: {wr_addr, wr_res} expected per write-back
  // ---------------------------------------------------------------------------
  logic [68:0] exp_q[$];
  logic [63:0] last_res;
  logic [4:0]  last_addr;
  int          done_cnt = 0;

  always @(negedge clk) begin
    if (rd_en || wr_en || done)
      check("strobe_excl", 64'(int'(rd_en) + int'(wr_en) + int'(done)), 64'd1);
    if (done) done_cnt++;
    if (wr_en) begin
      last_res  = wr_res;
      last_addr = wr_addr;
      if (exp_q.size() == 0) begin
        check("wr_unexpected", 64'd1, 64'd0);
      end else begin
        logic [68:0] e;
        e = exp_q.pop_front();
        check("wr_addr", 64'(wr_addr), 64'(e[68:64]));
        check("wr_res", wr_res, e[63:0]);
      end
    end
  end

  // Reference ALU from the opcode definitions.
  function automatic void model(input logic [3:0] op, input logic [31:0] a,
                                input logic [31:0] b, output logic [63:0] res,
                                output logic bad);
    longint sa, sb;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    res = '0;
    bad = 1'b0;
    case (op)
      4'd0: res = '0;
      4'd1: res = sa;
      4'd2: res = sb;
      4'd3: res = sa + sb;
      4'd4: res = sa - sb;
      4'd5: res = sa * sb;
`ifdef INSTR_EXEC_DIV_EN
      4'd6: res = (sb == 0) ? 64'd0 : sa / sb;
      4'd7: res = (sb == 0) ? 64'd0 : sa % sb;
`endif
      default: bad = 1'b1;
    endcase
  endfunction

  task automatic set_entry(input int addr, input logic [3:0] op,
                           input logic [31:0] a, input logic [31:0] b);
    mem[addr] = {op, a, b};
  endtask

  // Drive one batch; expected writes are queued before start is driven.
  // poke_busy pulses a different start request while the batch is running.
  task automatic run_batch(input logic [4:0] base, input logic [5:0] cnt,
                           input bit poke_busy);
    logic [63:0] res;
    logic        bad;
    logic        exp_err;
    int          lat;
    int          a;
    exp_err = 1'b0;
    for (int i = 0; i < int'(cnt); i++) begin
      a = (int'(base) + i) % 32;
      model(mem[a][67:64], mem[a][63:32], mem[a][31:0], res, bad);
      exp_q.push_back({5'(a), res});
      if (bad) exp_err = 1'b1;
    end
    @(negedge clk);
    start = 1'b1; base_addr = base; count = cnt;
    lat = 0;
    forever begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        start = 1'b0;
        if (cnt != 0) check("err_cleared", 64'(err), 64'd0);
      end
      if (poke_busy && lat == 2) begin
        start = 1'b1; base_addr = 5'd7; count = 6'd5;
      end
      if (poke_busy && lat == 3) start = 1'b0;
      if (done) break;
      if (lat > 400) begin
        check("done_timeout", 64'd0, 64'd1);
        break;
      end
    end
    check("latency", 64'(lat), 64'(3 * int'(cnt) + 1));
    check("exec_cnt", 64'(exec_cnt), 64'(cnt));
    check("err", 64'(err), 64'(exp_err));
    check("sb_empty", 64'(exp_q.size()), 64'd0);
    @(negedge clk);
    check("idle_busy", 64'(busy), 64'd0);
    check("err_held", 64'(err), 64'(exp_err));
    exp_q.delete();
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int lat;
    int dc;
    for (int i = 0; i < 32; i++) mem[i] = '0;

    repeat (3) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_rd_en", 64'(rd_en), 64'd0);
    check("rst_wr_en", 64'(wr_en), 64'd0);
    check("rst_rd_addr", 64'(rd_addr), 64'd0);
    check("rst_wr_res", wr_res, 64'd0);
    check("rst_exec_cnt", 64'(exec_cnt), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_state", 64'(dbg_state), 64'd0);
    reset = 1'b0;

    // ADD 7 + -3 at entry 2
    set_entry(2, 4'd3, 32'd7, -32'sd3);
    run_batch(5'd2, 6'd1, 1'b0);
    check("add_res", last_res, 64'd4);
    check("add_addr", 64'(last_addr), 64'd2);

    // MULT wrapping 30 -> 31 -> 0
    for (int i = 0; i < 3; i++) set_entry((30 + i) % 32, 4'd5, -32'sd65536, 32'sd65536);
    run_batch(5'd30, 6'd3, 1'b0);
    check("mult_res", last_res, -64'sd4294967296);
    check("mult_wrap_addr", 64'(last_addr), 64'd0);

    // DIV / MOD
    set_entry(4, 4'd6, -32'sd7, 32'sd2);
    run_batch(5'd4, 6'd1, 1'b0);
`ifdef INSTR_EXEC_DIV_EN
    check("div_res", last_res, -64'sd3);
`else
    check("div_res", last_res, 64'd0);
`endif
    set_entry(5, 4'd7, -32'sd7, 32'sd2);
    run_batch(5'd5, 6'd1, 1'b0);
`ifdef INSTR_EXEC_DIV_EN
    check("mod_res", last_res, -64'sd1);
`else
    check("mod_res", last_res, 64'd0);
`endif
    set_entry(6, 4'd6, 32'sd5, 32'sd0);
    run_batch(5'd6, 6'd1, 1'b0);
    check("div0_res", last_res, 64'd0);
`ifdef INSTR_EXEC_DIV_EN
    check("div0_err", 64'(err), 64'd0);
`else
    check("div0_err", 64'(err), 64'd1);
`endif

    // Unsupported opcode: err stays set after done, next start clears it
    set_entry(0, 4'hF, 32'd123, 32'd456);
    run_batch(5'd0, 6'd1, 1'b0);
    check("bad_res", last_res, 64'd0);
    check("bad_err", 64'(err), 64'd1);
    repeat (3) @(negedge clk);
    check("bad_err_sticky", 64'(err), 64'd1);

    // count = 0 also counts as an accepted start and clears err
    run_batch(5'd9, 6'd0, 1'b0);
    check("zero_err", 64'(err), 64'd0);

    // start during busy is ignored
    set_entry(12, 4'd1, 32'd11, 32'd0);
    set_entry(13, 4'd2, 32'd0, -32'sd22);
    run_batch(5'd12, 6'd2, 1'b1);

    // Random batches
    for (int t = 0; t < 8; t++) begin
      int b;
      int c;
      b = $urandom_range(0, 31);
      c = $urandom_range(1, 6);
      for (int i = 0; i < c; i++)
        set_entry((b + i) % 32, 4'($urandom_range(0, 9)), $urandom, $urandom);
      run_batch(5'(b), 6'(c), 1'b0);
    end

    // Reset in EXEC of the 2nd of 4 instructions
    for (int i = 0; i < 4; i++) set_entry(10 + i, 4'd3, 32'(i), 32'd100);
    exp_q.push_back({5'd10, 64'd100});
    dc = done_cnt;
    @(negedge clk);
    start = 1'b1; base_addr = 5'd10; count = 6'd4;
    lat = 0;
    while (lat < 5) begin
      @(negedge clk);
      lat++;
      if (lat == 1) start = 1'b0;
    end
    check("pre_rst_state", 64'(dbg_state), 64'd2);
    reset = 1'b1;
    @(negedge clk);
    check("abort_state", 64'(dbg_state), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_wr_en", 64'(wr_en), 64'd0);
    check("abort_rd_en", 64'(rd_en), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_addr", 64'(wr_addr), 64'd0);
    check("abort_res", wr_res, 64'd0);
    check("abort_cnt", 64'(exec_cnt), 64'd0);
    check("abort_err", 64'(err), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (12) @(negedge clk);
    check("abort_no_done", 64'(done_cnt - dc), 64'd0);
    check("abort_sb_empty", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
